// File: rtl/mem_dma_copy.sv
// Block-copy engine in front of a single-port byte-addressed big-endian memory.
// Passes the CPU through while idle; on start it owns the port and copies with memmove semantics.
module mem_dma_copy #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              byte_mode,
  output logic              busy,
  output logic              done,
  output logic              cpu_stall,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wData,
  input  logic              cpu_mWrite,
  input  logic              cpu_mByte,
  input  logic              cpu_mRead,
  output logic [DATA_W-1:0] cpu_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wData,
  output logic              mem_mWrite,
  output logic              mem_mByte,
  output logic              mem_mRead,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int SPAN_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              byte_mode_q, byte_mode_d;
  logic              desc_q, desc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] req_stride;
  logic [ADDR_W-1:0] req_offset;
  logic [SPAN_W-1:0] req_span;
  logic [SPAN_W-1:0] req_src_end;
  logic              req_desc;
  logic [ADDR_W-1:0] step_stride;

  // Direction is decided on the unwrapped span so a region ending past the
  // top of memory is never mistaken for an overlap.
  always_comb begin
    req_stride  = byte_mode ? ADDR_W'(1) : ADDR_W'(2);
    req_span    = byte_mode ? SPAN_W'(len) : (SPAN_W'(len) << 1);
    req_src_end = SPAN_W'(src_addr) + req_span;
    req_desc    = (dst_addr > src_addr) && (SPAN_W'(dst_addr) < req_src_end);
    req_offset  = req_span[ADDR_W-1:0] - req_stride;
    step_stride = byte_mode_q ? ADDR_W'(1) : ADDR_W'(2);
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remain_d    = remain_q;
    buf_d       = buf_q;
    byte_mode_d = byte_mode_q;
    desc_d      = desc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          byte_mode_d = byte_mode;
          desc_d      = req_desc;
          src_ptr_d   = req_desc ? src_addr + req_offset : src_addr;
          dst_ptr_d   = req_desc ? dst_addr + req_offset : dst_addr;
          remain_d    = len;
          busy_d      = 1'b1;
          if (len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        buf_d   = byte_mode_q ? {{(DATA_W-8){1'b0}}, mem_data[7:0]} : mem_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_ptr_d = desc_q ? src_ptr_q - step_stride : src_ptr_q + step_stride;
        dst_ptr_d = desc_q ? dst_ptr_q - step_stride : dst_ptr_q + step_stride;
        remain_d  = remain_q - ADDR_W'(1);
        if (remain_q == ADDR_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remain_q    <= '0;
      buf_q       <= '0;
      byte_mode_q <= 1'b0;
      desc_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remain_q    <= remain_d;
      buf_q       <= buf_d;
      byte_mode_q <= byte_mode_d;
      desc_q      <= desc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_stall = busy_q;

  // Memory port mux: the CPU owns it only in IDLE; the engine never asserts both strobes.
  always_comb begin
    mem_addr   = '0;
    mem_wData  = '0;
    mem_mWrite = 1'b1;
    mem_mRead  = 1'b1;
    mem_mByte  = 1'b0;
    cpu_data   = '0;
    unique case (state_q)
      S_IDLE: begin
        mem_addr   = cpu_addr;
        mem_wData  = cpu_wData;
        mem_mWrite = cpu_mWrite;
        mem_mRead  = cpu_mRead;
        mem_mByte  = cpu_mByte;
        cpu_data   = mem_data;
      end
      S_READ: begin
        mem_addr  = src_ptr_q;
        mem_mRead = 1'b0;
        mem_mByte = byte_mode_q;
      end
      S_WRITE: begin
        mem_addr   = dst_ptr_q;
        mem_mWrite = 1'b0;
        mem_mByte  = byte_mode_q;
        mem_wData  = byte_mode_q ? {{(DATA_W-8){1'b0}}, buf_q[7:0]} : buf_q;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dma_copy.sv
// Bench for mem_dma_copy: behavioural big-endian memory, write/done scoreboard
// fed by directed copies, and a negedge monitor that pops and compares.
module tb_mem_dma_copy;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        byte_mode = 1'b0;
  logic        busy, done, cpu_stall;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wData = '0;
  logic        cpu_mWrite = 1'b1;
  logic        cpu_mByte = 1'b0;
  logic        cpu_mRead = 1'b1;
  logic [15:0] cpu_data;
  logic [15:0] mem_addr, mem_wData, mem_data;
  logic        mem_mWrite, mem_mByte, mem_mRead;

  mem_dma_copy dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .byte_mode(byte_mode),
    .busy(busy), .done(done), .cpu_stall(cpu_stall),
    .cpu_addr(cpu_addr), .cpu_wData(cpu_wData), .cpu_mWrite(cpu_mWrite),
    .cpu_mByte(cpu_mByte), .cpu_mRead(cpu_mRead), .cpu_data(cpu_data),
    .mem_addr(mem_addr), .mem_wData(mem_wData), .mem_mWrite(mem_mWrite),
    .mem_mByte(mem_mByte), .mem_mRead(mem_mRead), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  logic [7:0]  mem [0:65535];
  logic [15:0] addr_p1;
  assign addr_p1  = mem_addr + 16'd1;
  assign mem_data = mem_mByte ? {8'h00, mem[mem_addr]} : {mem[mem_addr], mem[addr_p1]};

  always @(posedge clk) begin
    if (!mem_mWrite) begin
      if (mem_mByte) begin
        mem[mem_addr] = mem_wData[7:0];
      end else begin
        mem[mem_addr] = mem_wData[15:8];
        mem[addr_p1]  = mem_wData[7:0];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        bmode;
  } wr_t;

  wr_t  exp_wr[$];
  int   exp_done[$];
  logic exp_bmode = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every engine strobe and every done pulse against the queues.
  always @(negedge clk) begin
    if (reset && busy) begin
      if (!mem_mRead && !mem_mWrite) check("both_strobes_low", 1, 0);
      if (!mem_mRead) check("read_byte_sel", mem_mByte, exp_bmode);
      if (!mem_mWrite) begin
        check("write_expected", exp_wr.size(), 1 + (exp_wr.size() > 1 ? exp_wr.size() - 1 : 0));
        if (exp_wr.size() > 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          check("write_addr", mem_addr, w.addr);
          check("write_data", mem_wData, w.data);
          check("write_byte_sel", mem_mByte, w.bmode);
        end
      end
    end
    if (done) begin
      check("done_expected", exp_done.size() > 0, 1);
      if (exp_done.size() > 0) check("done_cycle", cyc, exp_done.pop_front());
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d, input logic b);
    wr_t w;
    w.addr = a; w.data = d; w.bmode = b;
    exp_wr.push_back(w);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    start      = 1'b0;
    cpu_mRead  = 1'b1;
    cpu_mWrite = 1'b1;
    cpu_mByte  = 1'b0;
    cpu_addr   = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h3a; mem[16'h0001] = 8'hdc;
    mem[16'h0004] = 8'h13; mem[16'h0005] = 8'h42;
    mem[16'h0006] = 8'had; mem[16'h0007] = 8'hde;
    mem[16'h0008] = 8'hef; mem[16'h0009] = 8'hbe;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issues start in the current cycle N; returns at the negedge of cycle N+1.
  task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input logic bm, input bit expect_done, output int n);
    src_addr  = s;
    dst_addr  = d;
    len       = l;
    byte_mode = bm;
    exp_bmode = bm;
    start     = 1'b1;
    n         = cyc;
    if (expect_done) exp_done.push_back(n + 2 * int'(l) + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic check_word(input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] a1;
    a1 = a + 16'd1;
    check($sformatf("mem_word_%04h", a), {mem[a], mem[a1]}, exp);
  endtask

  task automatic check_byte(input logic [15:0] a, input logic [7:0] exp);
    check($sformatf("mem_byte_%04h", a), mem[a], exp);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_writes_drained"}, exp_wr.size(), 0);
    check({tag, "_done_drained"}, exp_done.size(), 0);
  endtask

  initial begin
    int n;
    do_reset();

    // Idle pass-through read.
    cpu_addr  = 16'h0000;
    cpu_mRead = 1'b0;
    #1;
    check("pass_cpu_data", cpu_data, 16'h3adc);
    check("pass_mem_rd", mem_mRead, 0);
    check("pass_mem_addr", mem_addr, 16'h0000);
    check("pass_stall", cpu_stall, 0);
    cpu_mRead = 1'b1;
    @(negedge clk);

    // Word copy 0x0004 -> 0x0100, len 3.
    push_wr(16'h0100, 16'h1342, 1'b0);
    push_wr(16'h0102, 16'hadde, 1'b0);
    push_wr(16'h0104, 16'hefbe, 1'b0);
    start_copy(16'h0004, 16'h0100, 16'd3, 1'b0, 1'b1, n);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("busy_cycle_N+%0d", k), busy, (k <= 7));
      if (k == 3) begin
        cpu_mRead = 1'b0;
        #1;
        check("copy_stall", cpu_stall, 1);
        check("copy_cpu_data", cpu_data, 16'h0000);
      end
      @(negedge clk);
    end
    cpu_mRead = 1'b1;
    check_word(16'h0100, 16'h1342);
    check_word(16'h0102, 16'hadde);
    check_word(16'h0104, 16'hefbe);
    check_drained("word");

    // Byte copy 0x0000 -> 0x0201, len 3.
    push_wr(16'h0201, 16'h003a, 1'b1);
    push_wr(16'h0202, 16'h00dc, 1'b1);
    push_wr(16'h0203, 16'h0000, 1'b1);
    start_copy(16'h0000, 16'h0201, 16'd3, 1'b1, 1'b1, n);
    wait_idle(20);
    @(negedge clk);
    check_byte(16'h0200, 8'h00);
    check_byte(16'h0201, 8'h3a);
    check_byte(16'h0202, 8'hdc);
    check_byte(16'h0203, 8'h00);
    check_byte(16'h0204, 8'h00);
    check_drained("byte");

    // Overlap, dst above src: descending order.
    do_reset();
    push_wr(16'h000a, 16'hefbe, 1'b0);
    push_wr(16'h0008, 16'hadde, 1'b0);
    push_wr(16'h0006, 16'h1342, 1'b0);
    start_copy(16'h0004, 16'h0006, 16'd3, 1'b0, 1'b1, n);
    wait_idle(20);
    @(negedge clk);
    check_word(16'h0006, 16'h1342);
    check_word(16'h0008, 16'hadde);
    check_word(16'h000a, 16'hefbe);
    check_drained("desc");

    // Overlap, dst below src: ascending order.
    do_reset();
    push_wr(16'h0004, 16'hadde, 1'b0);
    push_wr(16'h0006, 16'hefbe, 1'b0);
    start_copy(16'h0006, 16'h0004, 16'd2, 1'b0, 1'b1, n);
    wait_idle(20);
    @(negedge clk);
    check_word(16'h0004, 16'hadde);
    check_word(16'h0006, 16'hefbe);
    check_drained("asc");

    // len = 0: immediate done, no strobes.
    do_reset();
    start_copy(16'h0010, 16'h0020, 16'd0, 1'b0, 1'b1, n);
    check("len0_done", done, 1);
    check("len0_rd_high", mem_mRead, 1);
    check("len0_wr_high", mem_mWrite, 1);
    wait_idle(5);
    @(negedge clk);
    check_drained("len0");

    // A second start during a copy is ignored.
    do_reset();
    push_wr(16'h0400, 16'h1342, 1'b0);
    push_wr(16'h0402, 16'hadde, 1'b0);
    push_wr(16'h0404, 16'hefbe, 1'b0);
    push_wr(16'h0406, 16'h0000, 1'b0);
    start_copy(16'h0004, 16'h0400, 16'd4, 1'b0, 1'b1, n);
    repeat (2) @(negedge clk);
    src_addr = 16'h0000;
    dst_addr = 16'h0500;
    len      = 16'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(30);
    repeat (4) @(negedge clk);
    check_word(16'h0406, 16'h0000);
    check_word(16'h0500, 16'h0000);
    check_drained("restart");

    // Reset during the third READ of a len=4 copy.
    do_reset();
    push_wr(16'h0300, 16'h1342, 1'b0);
    push_wr(16'h0302, 16'hadde, 1'b0);
    start_copy(16'h0004, 16'h0300, 16'd4, 1'b0, 1'b0, n);
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_read", mem_mRead, 0);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rd_high", mem_mRead, 1);
    check("abort_wr_high", mem_mWrite, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check_word(16'h0300, 16'h1342);
    check_word(16'h0302, 16'hadde);
    check_word(16'h0304, 16'h0000);
    check_word(16'h0306, 16'h0000);
    check_drained("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
